johnson_counter: RTL and testbench

JOHNSON_COUNTER -- requirements
Module: johnson_counter

---
 rtl/johnson_counter_pkg.sv | 11 +
 rtl/johnson_decode.sv | 43 ++++
 rtl/johnson_counter.sv | 48 ++++
 tb/tb_johnson_counter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/johnson_counter_pkg.sv
// Shared constants and helpers for the Johnson counter and its decoder.
package johnson_counter_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Bits needed to index every state of a 2*width-long Johnson sequence.
  function automatic int phase_width(input int width);
    return $clog2(2 * width);
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational decode of a Johnson code into its sequence index and a
// legality flag.
module johnson_decode
  import johnson_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int PW = phase_width(WIDTH)
) (
  input  logic [WIDTH-1:0] count,
  output logic [PW-1:0]    phase,
  output logic             illegal
);

  logic [WIDTH-1:0] inv;
  logic             low_run;
  logic             high_run;
  logic [PW:0]      ones;
  logic [PW:0]      span;

  // A run of ones anchored at bit 0 has no carry overlap with itself + 1;
  // the complement test catches the runs anchored at the MSB.
  assign inv      = ~count;
  assign low_run  = ((count & (count + WIDTH'(1))) == '0);
  assign high_run = ((inv & (inv + WIDTH'(1))) == '0);
  assign illegal  = ~(low_run | high_run);
  assign span     = (PW+1)'(2 * WIDTH);

  always_comb begin
    ones = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + {{PW{1'b0}}, count[i]};
    end
  end

  always_comb begin
    phase = '0;
    if (!illegal) begin
      if (count[WIDTH-1]) phase = PW'(span - ones);
      else                phase = PW'(ones);
    end
  end

endmodule

// File: rtl/johnson_counter.sv
// Bidirectional Johnson counter with synchronous clear and one-cycle
// recovery from illegal codes.
module johnson_counter
  import johnson_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int PW = phase_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic [PW-1:0]    phase,
  output logic             illegal
);

  logic [WIDTH-1:0] count_p0;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] step_fwd;
  logic [WIDTH-1:0] step_rev;

  assign step_fwd = {count_p0[WIDTH-2:0], ~count_p0[WIDTH-1]};
  assign step_rev = {~count_p0[0], count_p0[WIDTH-1:1]};

  always_comb begin
    count_nxt = count_p0;
    if (clr)          count_nxt = '0;
    else if (illegal) count_nxt = '0;
    else if (en)      count_nxt = dir ? step_rev : step_fwd;
  end

  // Stage p0: the only state in the design.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_p0 <= '0;
    else     count_p0 <= count_nxt;
  end

  assign count = count_p0;

  johnson_decode #(.WIDTH(WIDTH)) u_decode (
    .count   (count_p0),
    .phase   (phase),
    .illegal (illegal)
  );

endmodule

// File: tb/tb_johnson_counter.sv
// Bench for johnson_counter at WIDTH=4 and WIDTH=3 against a table-driven
// sequence model.
module tb_johnson_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       dir;
  logic       clr;
  logic [3:0] count4;
  logic [2:0] phase4;
  logic       illegal4;
  logic [2:0] count3;
  logic [2:0] phase3;
  logic       illegal3;
  logic [3:0] fv;

  johnson_counter #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr),
    .count(count4), .phase(phase4), .illegal(illegal4)
  );

  johnson_counter #(.WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .clr(clr),
    .count(count3), .phase(phase3), .illegal(illegal3)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;
  int m4 = 0;
  int m3 = 0;

  // Position p of the sequence: p ones filled from the LSB, then ones
  // drained from the LSB end.
  function automatic int code_of(input int w, input int p);
    if (p <= w) return (1 << p) - 1;
    return ((1 << w) - 1) ^ ((1 << (p - w)) - 1);
  endfunction

  function automatic int phase_of(input int w, input int c);
    for (int p = 0; p < 2 * w; p++) if (code_of(w, p) == c) return p;
    return -1;
  endfunction

  function automatic int next_code(input int w, input int c, input bit r,
                                   input bit cl, input bit e, input bit d);
    int p;
    p = phase_of(w, c);
    if (r || cl || p < 0) return 0;
    if (!e) return c;
    if (d) return code_of(w, (p + 2 * w - 1) % (2 * w));
    return code_of(w, (p + 1) % (2 * w));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int p4;
    int p3;
    if (chk_on) begin
      p4 = phase_of(4, m4);
      p3 = phase_of(3, m3);
      check("count4",   {28'd0, count4}, m4);
      check("phase4",   {29'd0, phase4}, (p4 < 0) ? 0 : p4);
      check("illegal4", {31'd0, illegal4}, (p4 < 0) ? 1 : 0);
      check("count3",   {29'd0, count3}, m3);
      check("phase3",   {29'd0, phase3}, (p3 < 0) ? 0 : p3);
      check("illegal3", {31'd0, illegal3}, (p3 < 0) ? 1 : 0);
    end
  end

  task automatic step(input bit e, input bit d, input bit c);
    en = e; dir = d; clr = c;
    @(posedge clk);
    m4 = next_code(4, m4, rst, clr, en, dir);
    m3 = next_code(3, m3, rst, clr, en, dir);
    @(negedge clk);
  endtask

  task automatic force_code(input logic [3:0] v);
    fv = v;
    #1 force dut4.count_p0 = fv;
    #1 release dut4.count_p0;
    m4 = int'(v);
    #1;
  endtask

  int exp4 [10] = '{1, 3, 7, 15, 14, 12, 8, 0, 1, 3};
  int ph4  [10] = '{1, 2, 3, 4, 5, 6, 7, 0, 1, 2};
  int exp3 [10] = '{1, 3, 7, 6, 4, 0, 1, 3, 7, 6};
  int rev4 [4]  = '{3, 1, 0, 8};
  int rph4 [4]  = '{2, 1, 0, 7};

  initial begin
    rst = 1'b1; en = 1'b0; dir = 1'b0; clr = 1'b0; fv = '0;
    #1;
    check("reset_count4", {28'd0, count4}, 0);
    check("reset_phase4", {29'd0, phase4}, 0);
    check("reset_illegal4", {31'd0, illegal4}, 0);
    @(negedge clk);
    chk_on = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Forward run from reset at both widths.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0);
      check("fwd_count4", {28'd0, count4}, exp4[i]);
      check("fwd_phase4", {29'd0, phase4}, ph4[i]);
      check("fwd_count3", {29'd0, count3}, exp3[i]);
    end
    step(1'b1, 1'b0, 1'b0);
    check("at_0111", {28'd0, count4}, 7);

    // Immediate reversal.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 1'b0);
      check("rev_count4", {28'd0, count4}, rev4[i]);
      check("rev_phase4", {29'd0, phase4}, rph4[i]);
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);

    // Hold, then clear without enable.
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0);
      check("hold_count4", {28'd0, count4}, 14);
      check("hold_phase4", {29'd0, phase4}, 5);
    end
    step(1'b0, 1'b0, 1'b1);
    check("clr_count4", {28'd0, count4}, 0);

    // Illegal code recovery.
    force_code(4'b0101);
    check("forced_illegal4", {31'd0, illegal4}, 1);
    check("forced_phase4", {29'd0, phase4}, 0);
    step(1'b0, 1'b0, 1'b0);
    check("recover_count4", {28'd0, count4}, 0);
    check("recover_illegal4", {31'd0, illegal4}, 0);

    // Randomized traffic with occasional corrupted states.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 24) == 0) force_code(4'($urandom_range(0, 15)));
      step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 19) == 0);
    end

    // Asynchronous reset from 1100.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
    check("pre_rst_count4", {28'd0, count4}, 12);
    #2 rst = 1'b1;
    m4 = 0; m3 = 0;
    #1;
    check("async_rst_count4", {28'd0, count4}, 0);
    check("async_rst_phase4", {29'd0, phase4}, 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
    check("rst_hold_count4", {28'd0, count4}, 0);
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    check("first_rev_count4", {28'd0, count4}, 8);
    check("first_rev_count3", {29'd0, count3}, 4);
    step(1'b0, 1'b0, 1'b0);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
